// File: rtl/mod_n_down_counter_pkg.sv
// Shared constants and helpers for the modulo-N down counter family.
// The helpers keep preset saturation and the terminal value identical across instances.
package mod_n_down_counter_pkg;

   localparam int unsigned DEF_MODULUS = 13;
   localparam int unsigned DEF_WIDTH   = 4;

   // Highest legal count, loaded on clr and on wrap.
   function automatic logic [31:0] terminal_value(input int unsigned modulus);
      return 32'(modulus - 1);
   endfunction

   // Out-of-range presets clamp to the terminal value so no illegal state is ever entered.
   function automatic logic [31:0] sat_preset(input logic [31:0] d, input int unsigned modulus);
      return (d >= 32'(modulus)) ? terminal_value(modulus) : d;
   endfunction

endpackage

// File: rtl/mod_n_down_counter_core.sv
// Count register with clr > load > en priority, wrap/halt at zero, and the
// combinational borrow used to chain stages.
module dn_cnt_core
   import mod_n_down_counter_pkg::*;
#(
   parameter int unsigned MODULUS = DEF_MODULUS,
   parameter int unsigned WIDTH   = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             en,
   input  logic             oneshot,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             borrow
);

   localparam logic [WIDTH-1:0] TERM = WIDTH'(terminal_value(MODULUS));

   logic [WIDTH-1:0] q_next;

   // NOTE: q_next is assigned a default first so no path through the block infers a latch.
   always_comb begin
      q_next = q;
      if (load) begin
         q_next = WIDTH'(sat_preset(32'(d), MODULUS));
      end else if (en) begin
         if (q != '0)       q_next = q - WIDTH'(1);
         else if (!oneshot) q_next = TERM;
      end
   end

   // NOTE: state updates use non-blocking assignments so every bit switches on the same edge.
   always_ff @(posedge clk) begin
      if (clr) q <= TERM;
      else     q <= q_next;
   end

   // Deliberately independent of load/clr so a cascade decrements in one edge.
   assign borrow = en & (q == '0);

endmodule

// File: rtl/mod_n_down_counter.sv
// Presettable modulo-N down counter: count core plus the one-shot done flag.
// Parameter legality is checked at elaboration.
module mod_n_down_counter
   import mod_n_down_counter_pkg::*;
#(
   parameter int unsigned MODULUS = DEF_MODULUS,
   parameter int unsigned WIDTH   = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             oneshot,
   output logic [WIDTH-1:0] q,
   output logic             borrow,
   output logic             done
);

   generate
      if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
         $error("mod_n_down_counter: MODULUS must lie in 2..2**WIDTH");
      end
   endgenerate

   dn_cnt_core #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH)
   ) u_core (
      .clk     (clk),
      .clr     (clr),
      .load    (load),
      .en      (en),
      .oneshot (oneshot),
      .d       (d),
      .q       (q),
      .borrow  (borrow)
   );

   // done latches when a one-shot step lands on (or sits at) zero; only clr/load clear it.
   always_ff @(posedge clk) begin
      if (clr || load) begin
         done <= 1'b0;
      end else if (en && oneshot && (q == '0 || q == WIDTH'(1))) begin
         done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Directed test-plan steps followed by random stimulus, all checked against
// an arithmetic reference model of the counter; cascade of two mod-10 stages at the end.
module tb_mod_n_down_counter;

   localparam int M = 13;

   logic       clk = 1'b0;
   logic       clr = 1'b0, en = 1'b0, load = 1'b0, oneshot = 1'b0;
   logic [3:0] d = '0;
   logic [3:0] q;
   logic       borrow, done;

   logic       c_clr = 1'b0, c_load = 1'b0, c_en = 1'b0;
   logic [3:0] d_lo = '0, d_hi = '0;
   logic [3:0] q_lo, q_hi;
   logic       b_lo, b_hi, done_lo, done_hi;

   int n_compared  = 0;
   int n_mismatch  = 0;
   int m_q         = M - 1;
   int m_done      = 0;

   always #5 clk = ~clk;

   mod_n_down_counter #(.MODULUS(13), .WIDTH(4)) dut (
      .clk(clk), .clr(clr), .en(en), .load(load), .d(d), .oneshot(oneshot),
      .q(q), .borrow(borrow), .done(done)
   );

   mod_n_down_counter #(.MODULUS(10), .WIDTH(4)) u_lo (
      .clk(clk), .clr(c_clr), .en(c_en), .load(c_load), .d(d_lo), .oneshot(1'b0),
      .q(q_lo), .borrow(b_lo), .done(done_lo)
   );

   mod_n_down_counter #(.MODULUS(10), .WIDTH(4)) u_hi (
      .clk(clk), .clr(c_clr), .en(b_lo), .load(c_load), .d(d_hi), .oneshot(1'b0),
      .q(q_hi), .borrow(b_hi), .done(done_hi)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatch++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock of stimulus on the main counter; borrow checked before the edge, q/done after.
   task automatic step(input logic c, input logic l, input logic e, input logic o,
                       input logic [3:0] dv);
      @(negedge clk);
      clr = c; load = l; en = e; oneshot = o; d = dv;
      #1 check("borrow", 32'(borrow), 32'(e && m_q == 0));
      @(posedge clk);
      if (c) begin
         m_q = M - 1; m_done = 0;
      end else if (l) begin
         m_q = (int'(dv) >= M) ? M - 1 : int'(dv); m_done = 0;
      end else if (e) begin
         if (o) begin
            m_q = (m_q > 0) ? m_q - 1 : 0;
            if (m_q == 0) m_done = 1;
         end else begin
            m_q = (m_q + M - 1) % M;
         end
      end
      #1;
      check("q", 32'(q), 32'(m_q));
      check("done", 32'(done), 32'(m_done));
   endtask

   initial begin
      int v;
      // Reset and wrap
      step(1, 0, 0, 0, 0);
      check("q_after_reset", 32'(q), 32'd12);
      for (int i = 0; i < 28; i++) step(0, 0, 1, 0, 0);

      // Preset saturation, load beats en
      step(0, 1, 0, 0, 4'd9);
      check("load9", 32'(q), 32'd9);
      step(0, 1, 0, 0, 4'd15);
      check("load15_sat", 32'(q), 32'd12);
      step(0, 1, 1, 0, 4'd5);
      check("load_en", 32'(q), 32'd5);

      // One-shot
      step(0, 1, 0, 1, 4'd3);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0);
      check("oneshot_done", 32'(done), 32'd1);
      step(0, 0, 1, 0, 0);            // oneshot released while halted: wrap, done stays
      check("release_wrap", 32'(q), 32'd12);
      step(0, 1, 0, 1, 4'd4);
      check("done_cleared", 32'(done), 32'd0);
      step(0, 1, 0, 1, 4'd0);         // N=0: done sets one enabled cycle later
      step(0, 0, 1, 1, 0);
      check("n0_done", 32'(done), 32'd1);

      // Enable gaps from 7
      step(0, 1, 0, 0, 4'd7);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      check("gap_end", 32'(q), 32'd4);

      // Reset mid-operation
      step(0, 1, 0, 1, 4'd4);
      step(1, 1, 1, 1, 4'd2);
      check("clr_mid", 32'(q), 32'd12);

      // Random stimulus
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)));
      end

      // Cascade of two mod-10 stages loaded to 20
      @(negedge clk); c_clr = 1'b1;
      @(negedge clk); c_clr = 1'b0; c_load = 1'b1; d_lo = 4'd0; d_hi = 4'd2;
      @(negedge clk); c_load = 1'b0;
      v = 20;
      check("casc_lo_init", 32'(q_lo), 32'(v % 10));
      check("casc_hi_init", 32'(q_hi), 32'(v / 10));
      c_en = 1'b1;
      for (int i = 0; i < 21; i++) begin
         #1 check("casc_hi_en", 32'(b_lo), 32'(v % 10 == 0));
         @(posedge clk);
         v = (v + 99) % 100;
         #1;
         check("casc_lo", 32'(q_lo), 32'(v % 10));
         check("casc_hi", 32'(q_hi), 32'(v / 10));
         @(negedge clk);
      end
      check("casc_final", 32'(q_hi) * 10 + 32'(q_lo), 32'd99);
      c_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
